// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM with memory-stall timeout and sticky fault.
// Optional BNE support is enabled by defining MIPS_MC_BNE_EN.
module mips_mc_control #(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       memread,
    output logic       memwrite,
    output logic       alusrca,
    output logic       pcen,
    output logic       memtoreg,
    output logic       regdst,
    output logic       iord,
    output logic       regwrite,
    output logic       irwrite,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsource,
    output logic [1:0] aluop,
    output logic [3:0] state,
    output logic       fault
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        BNEEX   = 4'd9,
        JEX     = 4'd10,
        ADDIEX  = 4'd11,
        ADDIWB  = 4'd12,
        FAULT   = 4'd15
    } state_t;

    localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MAX_WAIT);

    state_t           cur_st;
    state_t           nxt_st;
    logic [CNT_W-1:0] wait_cnt;
    logic             fault_q;
    logic             waiting;
    logic             timeout;

    assign waiting = (cur_st == FETCH) || (cur_st == MEMRD) || (cur_st == MEMWR);
    // A completing access on the limit cycle still proceeds normally.
    assign timeout = waiting && !mem_ready && (wait_cnt == WAIT_LIM);
    assign state   = cur_st;
    assign fault   = fault_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_st   <= FETCH;
            wait_cnt <= '0;
            fault_q  <= 1'b0;
        end else begin
            cur_st   <= nxt_st;
            fault_q  <= fault_q | (nxt_st == FAULT);
            if (waiting && !mem_ready && !timeout)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
        end
    end

    always_comb begin
        nxt_st   = cur_st;
        memread  = 1'b0;
        memwrite = 1'b0;
        alusrca  = 1'b0;
        pcen     = 1'b0;
        memtoreg = 1'b0;
        regdst   = 1'b0;
        iord     = 1'b0;
        regwrite = 1'b0;
        irwrite  = 1'b0;
        alusrcb  = 2'b00;
        pcsource = 2'b00;
        aluop    = 2'b00;
        case (cur_st)
            FETCH: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcen    = mem_ready;
                if (mem_ready) nxt_st = DECODE;
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    6'b100011, 6'b101011: nxt_st = MEMADR;
                    6'b000000:            nxt_st = RTYPEEX;
                    6'b000100:            nxt_st = BEQEX;
`ifdef MIPS_MC_BNE_EN
                    6'b000101:            nxt_st = BNEEX;
`endif
                    6'b000010:            nxt_st = JEX;
                    6'b001000:            nxt_st = ADDIEX;
                    default:              nxt_st = FAULT;
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                nxt_st  = (op == 6'b100011) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
                if (mem_ready) nxt_st = MEMWB;
            end
            MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                nxt_st   = FETCH;
            end
            MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
                if (mem_ready) nxt_st = FETCH;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
                nxt_st  = RTYPEWB;
            end
            RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
                nxt_st   = FETCH;
            end
            BEQEX, BNEEX: begin
                alusrca  = 1'b1;
                aluop    = 2'b01;
                pcsource = 2'b01;
                pcen     = (cur_st == BEQEX) ? zero : ~zero;
                nxt_st   = FETCH;
            end
            JEX: begin
                pcsource = 2'b10;
                pcen     = 1'b1;
                nxt_st   = FETCH;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                nxt_st  = ADDIWB;
            end
            ADDIWB: begin
                regwrite = 1'b1;
                nxt_st   = FETCH;
            end
            FAULT:   nxt_st = FAULT;
            default: nxt_st = FAULT;
        endcase
        if (timeout) nxt_st = FAULT;
        // Reset holds the register in FETCH, whose strobes must not escape.
        if (reset) begin
            memread  = 1'b0;
            memwrite = 1'b0;
            alusrca  = 1'b0;
            pcen     = 1'b0;
            memtoreg = 1'b0;
            regdst   = 1'b0;
            iord     = 1'b0;
            regwrite = 1'b0;
            irwrite  = 1'b0;
            alusrcb  = 2'b00;
            pcsource = 2'b00;
            aluop    = 2'b00;
        end
    end

endmodule

// File: doc/mips_mc_control.md
MIPS_MC_CONTROL -- requirements
Module: mips_mc_control

Interface
REQ-001 Parameter MAX_WAIT, default 15, SHALL set the max consecutive cycles a memory access may stall before fault (legal 1..255).
REQ-002 Parameter CNT_W, default 8, SHALL set the wait-counter width; legal only if 2^CNT_W > MAX_WAIT.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 op  input  6  instruction opcode from the instruction register.
REQ-007 zero  input  1  ALU zero flag.
REQ-008 mem_ready  input  1  memory completes the current read/write this cycle.
REQ-009 memread, memwrite, alusrca, pcen, memtoreg, regdst, iord, regwrite, irwrite  output  1 each  datapath strobes/selects.
REQ-010 alusrcb, pcsource, aluop  output  2 each  ALU-B select, PC source, ALU op class.
REQ-011 state  output  4  current state code, for probing.
REQ-012 fault  output  1  sticky: illegal opcode or memory timeout.

Function
REQ-013 States/codes SHALL be: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, BNEEX 9, JEX 10, ADDIEX 11, ADDIWB 12, FAULT 15.
REQ-014 Every output not listed for the current state SHALL be 0.
REQ-015 FETCH: memread=1, alusrcb=01; irwrite=pcen=mem_ready; stays in FETCH while mem_ready=0, else goes to DECODE.
REQ-016 DECODE: alusrcb=11; op 100011/101011 -> MEMADR, 000000 -> RTYPEEX, 000100 -> BEQEX, 000101 -> BNEEX (see REQ-029), 000010 -> JEX, 001000 -> ADDIEX, any other -> FAULT.
REQ-017 MEMADR: alusrca=1, alusrcb=10; op 100011 -> MEMRD, else -> MEMWR.
REQ-018 MEMRD: memread=1, iord=1; stays until mem_ready=1, then -> MEMWB.
REQ-019 MEMWB: regwrite=1, memtoreg=1 -> FETCH.
REQ-020 MEMWR: memwrite=1, iord=1; stays until mem_ready=1, then -> FETCH.
REQ-021 RTYPEEX: alusrca=1, aluop=10 -> RTYPEWB; RTYPEWB: regdst=1, regwrite=1 -> FETCH.
REQ-022 BEQEX: alusrca=1, aluop=01, pcsource=01, pcen=zero -> FETCH; BNEEX identical except pcen=~zero.
REQ-023 JEX: pcsource=10, pcen=1 -> FETCH.
REQ-024 ADDIEX: alusrca=1, alusrcb=10 -> ADDIWB; ADDIWB: regwrite=1 -> FETCH.
REQ-025 Wait counter SHALL increment each cycle in FETCH/MEMRD/MEMWR with mem_ready=0 and clear on mem_ready=1 or any other state; when it reaches MAX_WAIT with mem_ready still 0, next state SHALL be FAULT (mem_ready=1 on that same cycle wins: normal transition).
REQ-026 FAULT: all strobes 0, fault=1, terminal until reset; fault SHALL be registered and sticky.
REQ-027 Branch/jump/R-type/addi latencies SHALL be 3, 3, 4, 4 cycles from FETCH-complete edge; lw 5, sw 4 with zero memory stall.

Reset
REQ-028 While reset=1: state=FETCH, counter=0, fault=0, and all strobe/select outputs forced 0 combinationally; after release, first FETCH cycle drives memread=1.

Configuration
REQ-029 Macro MIPS_MC_BNE_EN: defined -> op 000101 decodes to BNEEX per REQ-022; undefined -> BNEEX state unreachable and op 000101 decodes to FAULT.

Verification
REQ-030 Reset release, mem_ready=1, op=000000 -> states 0,1,6,7,0; regwrite=1 and regdst=1 only in state 7.
REQ-031 op=100011, mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, iord=1 throughout, then MEMWB with memtoreg=1.
REQ-032 op=000100: zero=1 -> pcen=1, pcsource=01 in BEQEX; zero=0 -> pcen=0.
REQ-033 MAX_WAIT=3, mem_ready=0 in FETCH -> FAULT after counter hits 3, fault=1 sticky, reset clears to state 0.
REQ-034 op=111111 in DECODE -> FAULT next cycle; op=000101 -> BNEEX with MIPS_MC_BNE_EN, FAULT without.
REQ-035 reset asserted mid-MEMWR -> outputs 0 immediately, state=0 on release, memwrite never reasserted.
